// File: rtl/fifo_unpacker.sv
// Drains a show-ahead FIFO and serializes each word into byte beats on a valid/ready stream.
// Keeps a wrapping count of fully transmitted words.
module fifo_unpacker #(
    parameter int unsigned MemWidth  = 40,
    parameter int unsigned ByteWidth = 8,
    parameter bit          MsbFirst  = 1'b0,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fifo_empty_i,
    input  logic [MemWidth-1:0]  fifo_data_i,
    output logic                 fifo_r_en_o,
    output logic                 out_valid_o,
    output logic [ByteWidth-1:0] out_data_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic [CntWidth-1:0]  word_cnt_o
);

    localparam int unsigned Lanes = MemWidth / ByteWidth;
    localparam int unsigned LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam logic [LaneW-1:0] LastLane = LaneW'(Lanes - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e              state_q;
    logic [MemWidth-1:0] word_q;
    logic [LaneW-1:0]    lane_q;
    logic [CntWidth-1:0] cnt_q;

    logic             send;
    logic             last_lane;
    logic             fire;
    logic             pop;
    logic [LaneW-1:0] lane_sel;

    assign send      = (state_q == StSend);
    assign last_lane = (lane_q == LastLane);
    assign fire      = send & out_ready_i;
    // A new word is only taken when nothing is held or the last lane leaves on this edge.
    assign pop       = rst_ni & ~fifo_empty_i & (~send | (fire & last_lane));
    assign lane_sel  = MsbFirst ? (LastLane - lane_q) : lane_q;

    assign fifo_r_en_o = pop;
    assign out_valid_o = send;
    assign out_last_o  = send & last_lane;
    assign out_data_o  = word_q[lane_sel*ByteWidth +: ByteWidth];
    assign busy_o      = send;
    assign word_cnt_o  = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            word_q  <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (fire && last_lane) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
            if (pop) begin
                word_q  <= fifo_data_i;
                lane_q  <= '0;
                state_q <= StSend;
            end else if (fire) begin
                if (last_lane) begin
                    state_q <= StIdle;
                end else begin
                    lane_q <= lane_q + LaneW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: two instances (LSB-first/16-bit count, MSB-first/4-bit count)
// share one FIFO model; a byte-queue reference model checks every cycle.
module tb_fifo_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [39:0] fifo_data = '0;
    logic        out_ready = 1'b0;

    logic        ren0, vld0, lst0, busy0;
    logic [7:0]  dat0;
    logic [15:0] cnt0;
    logic        ren1, vld1, lst1, busy1;
    logic [7:0]  dat1;
    logic [3:0]  cnt1;

    fifo_unpacker dut0 (
        .clk_i(clk), .rst_ni(rst_n), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
        .fifo_r_en_o(ren0), .out_valid_o(vld0), .out_data_o(dat0), .out_ready_i(out_ready),
        .out_last_o(lst0), .busy_o(busy0), .word_cnt_o(cnt0)
    );

    fifo_unpacker #(.MsbFirst(1'b1), .CntWidth(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
        .fifo_r_en_o(ren1), .out_valid_o(vld1), .out_data_o(dat1), .out_ready_i(out_ready),
        .out_last_o(lst1), .busy_o(busy1), .word_cnt_o(cnt1)
    );

    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    logic [39:0] fq[$];
    logic [7:0]  cur0[$];
    logic [7:0]  cur1[$];
    int unsigned mcnt0 = 0;
    int unsigned mcnt1 = 0;

    // Snapshot of dut0/dut1 outputs taken mid-cycle by the last call to cycle().
    logic        s_ren0, s_vld0, s_lst0;
    logic [7:0]  s_d0, s_d1;
    int unsigned s_cnt0, s_cnt1;

    typedef struct {
        bit          rdy;
        bit          ren;
        bit          vld;
        logic [7:0]  d0;
        logic [7:0]  d1;
        bit          lst;
        int unsigned cnt;
    } vec_t;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rdy, input bit rst_v);
        bit          e_vld, e_last, e_ren;
        logic [39:0] w;
        @(negedge clk);
        rst_n      = rst_v;
        out_ready  = rdy;
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? 40'h0 : fq[0];
        #1;
        if (!rst_v) begin
            e_vld  = 1'b0;
            e_last = 1'b0;
            e_ren  = 1'b0;
        end else begin
            e_vld  = (cur0.size() > 0);
            e_last = (cur0.size() == 1);
            e_ren  = !fifo_empty && (!e_vld || (rdy && e_last));
        end
        chk("ren0", ren0, e_ren);
        chk("ren1", ren1, e_ren);
        chk("valid0", vld0, e_vld);
        chk("valid1", vld1, e_vld);
        chk("busy0", busy0, e_vld);
        chk("busy1", busy1, e_vld);
        chk("last0", lst0, e_last);
        chk("last1", lst1, e_last);
        chk("cnt0", cnt0, rst_v ? mcnt0 : 0);
        chk("cnt1", cnt1, rst_v ? mcnt1 : 0);
        if (!rst_v) begin
            chk("rst_data0", dat0, 0);
            chk("rst_data1", dat1, 0);
        end else if (e_vld) begin
            chk("data0", dat0, cur0[0]);
            chk("data1", dat1, cur1[0]);
        end
        s_ren0 = ren0; s_vld0 = vld0; s_lst0 = lst0;
        s_d0 = dat0; s_d1 = dat1; s_cnt0 = cnt0; s_cnt1 = cnt1;
        @(posedge clk);
        if (!rst_v) begin
            cur0.delete();
            cur1.delete();
            mcnt0 = 0;
            mcnt1 = 0;
        end else begin
            if (e_vld && rdy) begin
                void'(cur0.pop_front());
                void'(cur1.pop_front());
                if (cur0.size() == 0) begin
                    mcnt0 = (mcnt0 + 1) % 65536;
                    mcnt1 = (mcnt1 + 1) % 16;
                end
            end
            if (e_ren) begin
                w = fq.pop_front();
                for (int i = 0; i < 5; i++) begin
                    cur0.push_back(w[8*i +: 8]);
                    cur1.push_back(w[8*(4-i) +: 8]);
                end
            end
        end
    endtask

    vec_t tbl[7];
    int unsigned nv;

    initial begin
        // Single word 40'h1122334455, out_ready held high.
        tbl[0] = '{1, 1, 0, 8'h00, 8'h00, 0, 0};
        tbl[1] = '{1, 0, 1, 8'h55, 8'h11, 0, 0};
        tbl[2] = '{1, 0, 1, 8'h44, 8'h22, 0, 0};
        tbl[3] = '{1, 0, 1, 8'h33, 8'h33, 0, 0};
        tbl[4] = '{1, 0, 1, 8'h22, 8'h44, 0, 0};
        tbl[5] = '{1, 0, 1, 8'h11, 8'h55, 1, 0};
        tbl[6] = '{1, 0, 0, 8'h00, 8'h00, 0, 1};

        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);

        fq.push_back(40'h1122334455);
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].rdy, 1'b1);
            chk("tbl_ren", s_ren0, tbl[i].ren);
            chk("tbl_valid", s_vld0, tbl[i].vld);
            chk("tbl_last", s_lst0, tbl[i].lst);
            chk("tbl_cnt", s_cnt0, tbl[i].cnt);
            if (tbl[i].vld) begin
                chk("tbl_lsb_data", s_d0, tbl[i].d0);
                chk("tbl_msb_data", s_d1, tbl[i].d1);
            end
        end

        // Back-to-back: three words, 15 beats with no bubble.
        for (int i = 0; i < 3; i++) fq.push_back({8'h10 + 8'(i), 32'hDEADBEEF});
        cycle(1'b1, 1'b1);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 1'b1);
            if (s_vld0) nv++;
        end
        chk("b2b_beats", nv, 15);
        cycle(1'b1, 1'b1);
        chk("b2b_idle", s_vld0, 0);
        chk("b2b_cnt", s_cnt0, 4);

        // Backpressure: 4-cycle stall on lane 2.
        fq.push_back(40'hA0B1C2D3E4);
        nv = 0;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(i == 4, 1'b1);
            chk("stall_data", s_d0, 8'hC2);
            chk("stall_valid", s_vld0, 1);
            chk("stall_ren", s_ren0, 0);
        end
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        chk("stall_last", s_lst0, 1);
        cycle(1'b1, 1'b1);
        chk("stall_cnt", s_cnt0, 5);

        // Reset mid-word: word A lanes 0,1 sent, then reset; B must start at lane 0.
        fq.push_back(40'h0102030405);
        fq.push_back(40'hAABBCCDDEE);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        chk("rst_valid", s_vld0, 0);
        chk("rst_ren", s_ren0, 0);
        chk("rst_cnt", s_cnt0, 0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        chk("rst_pop", s_ren0, 1);
        cycle(1'b1, 1'b1);
        chk("rst_lane0", s_d0, 8'hEE);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);

        // Counter wrap: 17 words into the 4-bit counter.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 17; i++) fq.push_back({$urandom, 8'(i)});
        for (int i = 0; i < 88; i++) cycle(1'b1, 1'b1);
        chk("wrap_cnt4", s_cnt1, 1);
        chk("wrap_cnt16", s_cnt0, 17);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if (fq.size() < 4 && $urandom_range(9) < 3) fq.push_back({$urandom, 8'($urandom)});
            cycle($urandom_range(3) != 0, $urandom_range(399) != 0);
        end
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
